clock_divider_multi: RTL and testbench

//  Parametrised successor to the fixed divide-by-3 Hack clock: NUM_CH independent

---
 rtl/clock_divider_multi_pkg.sv | 20 ++
 rtl/clock_divider_multi_div_channel.sv | 108 ++++++++++
 rtl/clock_divider_multi.sv | 43 ++++
 tb/tb_clock_divider_multi.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/clock_divider_multi_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clock_divider_multi_pkg;

    // Board clock feeding the dividers (100 MHz).
    localparam int BOARD_CLK_HZ     = 100_000_000;

    // Defaults: reproduce the legacy fixed divide-by-3 Hack clock.
    localparam int CNT_W_DEF        = 8;
    localparam int DEFAULT_DIV_DEF  = 3;
    localparam int DEFAULT_HIGH_DEF = 1;

    // What a channel does with its counter in a given cycle.
    typedef enum logic [1:0] {
        ACT_HOLD,   // en low: freeze cnt/out, suppress tick
        ACT_COUNT,  // normal advance / wrap
        ACT_APPLY,  // period end with a pending setting: swap in shadow regs
        ACT_SYNC    // global restart, pending settings take effect at once
    } ch_action_e;

endpackage

// File: rtl/clock_divider_multi_div_channel.sv
// One divider channel: counter, active/shadow settings, registered out/tick.
module clock_divider_multi_div_channel
    import clock_divider_multi_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
    parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic             load,
    output logic             pending,
    output logic             err,
    output logic             out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] cnt, div_act, high_act, div_sh, high_sh;
    logic [CNT_W-1:0] cnt_nxt, div_nxt, high_nxt;
    logic             out_nxt, tick_nxt, pending_nxt, load_ok, wrap;
    ch_action_e       action;

    // Count value at which out goes high. High time is clamped to the divisor
    // first, so the subtraction can never wrap.
    function automatic logic [CNT_W-1:0] on_threshold(input logic [CNT_W-1:0] d,
                                                      input logic [CNT_W-1:0] h);
        return (h >= d) ? '0 : d - h;
    endfunction

    // Decide this cycle's action and compute every next-state value.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        div_nxt  = div_act;
        high_nxt = high_act;
        cnt_nxt  = cnt;
        wrap     = (cnt == div_act - ONE);
        load_ok  = load && (div_in != '0);

        if (sync)                 action = ACT_SYNC;
        else if (!en)             action = ACT_HOLD;
        else if (wrap && pending) action = ACT_APPLY;
        else                      action = ACT_COUNT;

        case (action)
            ACT_SYNC: begin
                cnt_nxt = '0;
                if (pending) begin
                    div_nxt  = div_sh;
                    high_nxt = high_sh;
                end
            end
            ACT_APPLY: begin
                cnt_nxt  = '0;
                div_nxt  = div_sh;
                high_nxt = high_sh;
            end
            ACT_COUNT: cnt_nxt = wrap ? '0 : cnt + ONE;
            default:   cnt_nxt = cnt;
        endcase

        out_nxt  = (action == ACT_HOLD) ? out
                                        : (cnt_nxt >= on_threshold(div_nxt, high_nxt));
        tick_nxt = ((action == ACT_COUNT) || (action == ACT_APPLY))
                   && (cnt_nxt == div_nxt - ONE);

        // A load coinciding with an apply becomes the next pending setting.
        if (load_ok)                                         pending_nxt = 1'b1;
        else if ((action == ACT_SYNC) || (action == ACT_APPLY)) pending_nxt = 1'b0;
        else                                                 pending_nxt = pending;
    end

    // Channel state registers; shadow settings revert to defaults on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= DIV_RST;
            high_act <= HIGH_RST;
            div_sh   <= DIV_RST;
            high_sh  <= HIGH_RST;
            pending  <= 1'b0;
            err      <= 1'b0;
            out      <= 1'b0;
            tick     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt      <= cnt_nxt;
            div_act  <= div_nxt;
            high_act <= high_nxt;
            pending  <= pending_nxt;
            err      <= load && (div_in == '0);
            out      <= out_nxt;
            tick     <= tick_nxt;
            if (load_ok) begin
                div_sh  <= div_in;
                high_sh <= high_in;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing clk/reset/en/sync.
module clock_divider_multi
    import clock_divider_multi_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
    parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sync,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH*CNT_W-1:0] high_in,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH-1:0]       err,
    output logic [NUM_CH-1:0]       out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_multi_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_HIGH(DEFAULT_HIGH)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .sync   (sync),
            .div_in (div_in[i*CNT_W +: CNT_W]),
            .high_in(high_in[i*CNT_W +: CNT_W]),
            .load   (load[i]),
            .pending(pending[i]),
            .err    (err[i]),
            .out    (out[i]),
            .tick   (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (2 channels, 8-bit).
module tb_clock_divider_multi;
    import clock_divider_multi_pkg::*;

    localparam int HALF = 1_000_000_000 / BOARD_CLK_HZ / 2;

    logic        clk = 1'b0;
    logic        reset, en, sync;
    logic [15:0] div_in, high_in;
    logic [1:0]  load, pending, err, out, tick;
    int          total = 0;
    int          bad   = 0;

    clock_divider_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3), .DEFAULT_HIGH(1)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync), .div_in(div_in),
        .high_in(high_in), .load(load), .pending(pending), .err(err),
        .out(out), .tick(tick)
    );

    always #(HALF) clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ot(input string tag, input logic [1:0] o, input logic [1:0] t);
        check({tag, ".out"}, out, o);
        check({tag, ".tick"}, tick, t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sync = 1'b0; load = 2'b00;
        div_in = '0; high_in = '0;
        #(4*HALF + 2);
        check("rst.pending", pending, 2'b00);
        check("rst.err", err, 2'b00);
        chk_ot("rst", 2'b00, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b1;

        // 1: defaults, period 3, both channels identical
        step(); chk_ot("t1.e1", 2'b00, 2'b00);
        step(); chk_ot("t1.e2", 2'b11, 2'b11);
        step(); chk_ot("t1.e3", 2'b00, 2'b00);
        step(); chk_ot("t1.e4", 2'b00, 2'b00);
        step(); chk_ot("t1.e5", 2'b11, 2'b11);

        // 2: ch0 load div=4 high=2 at cnt=1, applied at end of old period
        step(); step();
        div_in = {8'd0, 8'd4}; high_in = {8'd0, 8'd2}; load = 2'b01;
        step(); load = 2'b00;
        check("t2.pend_set", pending, 2'b01);
        chk_ot("t2.e8", 2'b11, 2'b11);
        step(); check("t2.pend_clr", pending, 2'b00);
        chk_ot("t2.e9", 2'b00, 2'b00);
        step(); chk_ot("t2.e10", 2'b00, 2'b00);
        step(); chk_ot("t2.e11", 2'b11, 2'b10);
        step(); chk_ot("t2.e12", 2'b01, 2'b01);
        step(); chk_ot("t2.e13", 2'b00, 2'b00);

        // 3: ch1 load with div_in=0 rejected
        div_in = {8'd0, 8'd0}; high_in = {8'd1, 8'd0}; load = 2'b10;
        step(); load = 2'b00;
        check("t3.err", err, 2'b10);
        check("t3.pending", pending, 2'b00);
        chk_ot("t3.e14", 2'b10, 2'b10);
        step(); check("t3.err_clr", err, 2'b00);
        chk_ot("t3.e15", 2'b01, 2'b00);
        step(); chk_ot("t3.e16", 2'b01, 2'b01);
        step(); chk_ot("t3.e17", 2'b10, 2'b10);

        // 4: en low for 5 cycles mid-period
        step(); chk_ot("t4.e18", 2'b00, 2'b00);
        step(); chk_ot("t4.e19", 2'b01, 2'b00);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); chk_ot("t4.frozen", 2'b01, 2'b00);
        end
        en = 1'b1;
        step(); chk_ot("t4.resume", 2'b11, 2'b11);

        // 5: ch1 div=5 high=2 pending, then sync restarts both channels
        div_in = {8'd5, 8'd0}; high_in = {8'd2, 8'd0}; load = 2'b10;
        step(); load = 2'b00;
        check("t5.pend_set", pending, 2'b10);
        chk_ot("t5.e26", 2'b00, 2'b00);
        sync = 1'b1;
        step(); sync = 1'b0;
        check("t5.pend_clr", pending, 2'b00);
        chk_ot("t5.sync", 2'b00, 2'b00);
        step(); chk_ot("t5.e28", 2'b00, 2'b00);
        step(); chk_ot("t5.e29", 2'b01, 2'b00);
        step(); chk_ot("t5.e30", 2'b11, 2'b01);
        step(); chk_ot("t5.e31", 2'b10, 2'b10);
        step(); chk_ot("t5.e32", 2'b00, 2'b00);

        // 6a: clamp: ch0 high=0 -> out 0, ch1 high=7 div=4 -> out 1
        div_in = {8'd4, 8'd4}; high_in = {8'd7, 8'd0}; load = 2'b11;
        step(); load = 2'b00;
        check("t6.pend_set", pending, 2'b11);
        chk_ot("t6.e33", 2'b01, 2'b00);
        sync = 1'b1;
        step(); sync = 1'b0;
        chk_ot("t6.sync", 2'b10, 2'b00);
        step(); chk_ot("t6.e35", 2'b10, 2'b00);
        step(); chk_ot("t6.e36", 2'b10, 2'b00);
        step(); chk_ot("t6.e37", 2'b10, 2'b11);
        step(); chk_ot("t6.e38", 2'b10, 2'b00);

        // 6b: div=1 -> tick every cycle (ch0 high 0 -> out 0, ch1 high 1 -> out 1)
        div_in = {8'd1, 8'd1}; high_in = {8'd1, 8'd0}; load = 2'b11;
        step(); load = 2'b00;
        check("t6.div1_pend", pending, 2'b11);
        step(); chk_ot("t6.e40", 2'b10, 2'b00);
        step(); chk_ot("t6.e41", 2'b10, 2'b11);
        step(); check("t6.div1_apply", pending, 2'b00);
        chk_ot("t6.e42", 2'b10, 2'b11);
        step(); chk_ot("t6.e43", 2'b10, 2'b11);
        step(); chk_ot("t6.e44", 2'b10, 2'b11);

        // Asynchronous reset mid-operation, then defaults return
        reset = 1'b1;
        #1;
        check("rst2.pending", pending, 2'b00);
        chk_ot("rst2.async", 2'b00, 2'b00);
        step(); reset = 1'b0;
        step(); chk_ot("rst2.e1", 2'b00, 2'b00);
        step(); chk_ot("rst2.e2", 2'b11, 2'b11);
        step(); chk_ot("rst2.e3", 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
